// File: rtl/nonce_sched.sv
// Blake2b nonce scheduler: issues one job's nonces as m04, tracks in-flight words, buffers winners.
// Optional statistics counters are built when NONCE_SCHED_STATS_EN is defined.
module nonce_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int INFL_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_start,
  input  logic [31:0] job_count,
  input  logic [31:0] job_m04_hi,
  input  logic        abort,
  input  logic        issue_stall,
  output logic        issue_valid,
  output logic [63:0] issue_m04,
  input  logic        res_busy,
  input  logic        res_found,
  input  logic [31:0] res_nonce,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_nonce,
  output logic        sched_busy,
  output logic        done,
  output logic        overflow,
  output logic [47:0] stat_hashes,
  output logic [15:0] stat_found
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        nonce_q, rem_q, m04hi_q;
  logic               iv_q;
  logic [63:0]        m04_q;
  logic [INFL_W-1:0]  inflight_q, inflight_d;
  logic               overflow_q;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      cnt_q;

  logic accept, fire, dec, push_req, push_ok, pop, full, drop;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  assign accept     = job_valid && (state_q == S_IDLE);
  // Abort wins over an issue in the same cycle.
  assign fire       = (state_q == S_RUN) && !abort && !issue_stall;
  assign dec        = res_busy && (inflight_q != '0);
  assign inflight_d = inflight_q + INFL_W'(fire) - INFL_W'(dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (job_count == '0) ? S_DONE : S_RUN;
      S_RUN:   if (abort || (fire && rem_q == 32'd1)) state_d = S_DRAIN;
      S_DRAIN: if (inflight_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nonce_q    <= '0;
      rem_q      <= '0;
      m04hi_q    <= '0;
      iv_q       <= 1'b0;
      m04_q      <= '0;
      inflight_q <= '0;
    end else begin
      if (accept) begin
        nonce_q <= job_start;
        rem_q   <= job_count;
        m04hi_q <= job_m04_hi;
      end else if (fire) begin
        nonce_q <= nonce_q + 32'd1;
        rem_q   <= rem_q - 32'd1;
      end
      iv_q       <= fire;
      m04_q      <= fire ? {m04hi_q, bswap32(nonce_q)} : 64'd0;
      inflight_q <= inflight_d;
    end
  end

  // Result FIFO; a push into a full FIFO is accepted when the head pops in the same cycle.
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign out_valid = (cnt_q != '0);
  assign pop      = out_valid && out_ready;
  assign push_req = res_busy && res_found;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= res_nonce;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
      if (drop)        overflow_q <= 1'b1;
      else if (accept) overflow_q <= 1'b0;
    end
  end

  assign out_nonce   = out_valid ? mem[rd_ptr_q] : 32'd0;
  assign job_ready   = (state_q == S_IDLE);
  assign sched_busy  = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign overflow    = overflow_q;
  assign issue_valid = iv_q;
  assign issue_m04   = m04_q;

`ifdef NONCE_SCHED_STATS_EN
  logic [47:0] hashes_q;
  logic [15:0] found_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hashes_q <= '0;
      found_q  <= '0;
    end else begin
      if (fire && hashes_q != '1)    hashes_q <= hashes_q + 48'd1;
      if (push_req && found_q != '1) found_q  <= found_q + 16'd1;
    end
  end

  assign stat_hashes = hashes_q;
  assign stat_found  = found_q;
`else
  assign stat_hashes = '0;
  assign stat_found  = '0;
`endif

endmodule

// File: tb/tb_nonce_sched.sv
// Directed bench for nonce_sched; models a 3-deep hash pipeline feeding res_busy.
module tb_nonce_sched;

  localparam int STAGES = 3;
`ifdef NONCE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [31:0] job_start, job_count, job_m04_hi;
  logic        abort, issue_stall, issue_valid;
  logic [63:0] issue_m04;
  logic        res_busy, res_found;
  logic [31:0] res_nonce;
  logic        out_valid, out_ready;
  logic [31:0] out_nonce;
  logic        sched_busy, done, overflow;
  logic [47:0] stat_hashes;
  logic [15:0] stat_found;

  logic              man_busy;
  logic [STAGES:1]   vld_pipe;
  int                checks = 0;
  int                errors = 0;

  nonce_sched #(.FIFO_DEPTH(4), .INFL_W(8)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_start(job_start),
    .job_count(job_count), .job_m04_hi(job_m04_hi),
    .abort(abort), .issue_stall(issue_stall),
    .issue_valid(issue_valid), .issue_m04(issue_m04),
    .res_busy(res_busy), .res_found(res_found), .res_nonce(res_nonce),
    .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
    .sched_busy(sched_busy), .done(done), .overflow(overflow),
    .stat_hashes(stat_hashes), .stat_found(stat_found)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], issue_valid};
  end
  assign res_busy = vld_pipe[STAGES] | man_busy;

  function automatic logic [31:0] bs(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [31:0] t2n [3];
  logic [31:0] t5n [4];

  initial begin
    t2n = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
    t5n = '{32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0006};
    rst = 1'b1; job_valid = 1'b0; job_start = '0; job_count = '0; job_m04_hi = '0;
    abort = 1'b0; issue_stall = 1'b0; man_busy = 1'b0; res_found = 1'b0;
    res_nonce = '0; out_ready = 1'b0;
    tick; tick;
    chk1("rst_ready", job_ready, 1'b1);
    chk1("rst_iv", issue_valid, 1'b0);
    chk1("rst_busy", sched_busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_outv", out_valid, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);
    chk("rst_m04", issue_m04, 64'd0);
    chk("rst_hashes", 64'(stat_hashes), 64'd0);
    rst = 1'b0;
    tick;

    // 1: four consecutive issues, done once the pipeline drains
    job_valid = 1'b1; job_start = 32'h10; job_count = 32'd4; job_m04_hi = 32'hA5A50001;
    tick; job_valid = 1'b0;
    chk1("t1_busy", sched_busy, 1'b1);
    chk1("t1_iv_first", issue_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk1("t1_iv", issue_valid, 1'b1);
      chk("t1_m04", issue_m04, {32'hA5A50001, bs(32'h10 + 32'(i))});
    end
    tick;
    chk1("t1_iv_end", issue_valid, 1'b0);
    chk("t1_m04_end", issue_m04, 64'd0);
    tick; tick;
    chk1("t1_done_early", done, 1'b0);
    tick;
    chk1("t1_done", done, 1'b1);
    tick;
    chk1("t1_done_clr", done, 1'b0);
    chk1("t1_ready", job_ready, 1'b1);

    // 2: nonce wrap
    job_valid = 1'b1; job_start = 32'hFFFFFFFE; job_count = 32'd3; job_m04_hi = 32'h0BAD0002;
    tick; job_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t2_m04", issue_m04, {32'h0BAD0002, bs(t2n[i])});
    end
    tick;
    chk1("t2_iv_end", issue_valid, 1'b0);
    tick; tick;
    chk1("t2_done_early", done, 1'b0);
    tick;
    chk1("t2_done", done, 1'b1);
    tick;

    // 3: two stalled cycles open a gap, still four issues
    job_valid = 1'b1; job_start = 32'h20; job_count = 32'd4; job_m04_hi = 32'h33330003;
    tick; job_valid = 1'b0;
    tick;
    chk("t3_m04_0", issue_m04, {32'h33330003, bs(32'h20)});
    issue_stall = 1'b1;
    tick;
    chk1("t3_gap0", issue_valid, 1'b0);
    chk("t3_gap0_m04", issue_m04, 64'd0);
    tick;
    chk1("t3_gap1", issue_valid, 1'b0);
    issue_stall = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick;
      chk1("t3_iv", issue_valid, 1'b1);
      chk("t3_m04", issue_m04, {32'h33330003, bs(32'h20 + 32'(i))});
    end
    tick;
    chk1("t3_iv_end", issue_valid, 1'b0);
    tick; tick;
    chk1("t3_done_early", done, 1'b0);
    tick;
    chk1("t3_done", done, 1'b1);
    tick;

    // 4: abort after two issues; job offers while draining are refused
    job_valid = 1'b1; job_start = 32'h40; job_count = 32'd100; job_m04_hi = 32'h44440004;
    tick; job_valid = 1'b0;
    tick;
    chk("t4_m04_0", issue_m04, {32'h44440004, bs(32'h40)});
    tick;
    chk("t4_m04_1", issue_m04, {32'h44440004, bs(32'h41)});
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk1("t4_no_issue", issue_valid, 1'b0);
    chk1("t4_drain", sched_busy, 1'b1);
    job_valid = 1'b1; job_count = 32'd5;
    tick;
    chk1("t4_iv_after", issue_valid, 1'b0);
    tick;
    job_valid = 1'b0;
    chk1("t4_done_early", done, 1'b0);
    chk1("t4_not_ready", job_ready, 1'b0);
    tick;
    chk1("t4_done", done, 1'b1);
    tick;
    chk1("t4_ready", job_ready, 1'b1);
    chk("t4_hashes", 64'(stat_hashes), STATS ? 64'd13 : 64'd0);

    // 5: result FIFO fill, overflow, push+pop when full, drain in order
    res_found = 1'b1; res_nonce = 32'hDEAD0000;
    tick;
    chk1("t5_unqualified", out_valid, 1'b0);
    man_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_nonce = 32'hC0DE0000 + 32'(i);
      tick;
    end
    chk1("t5_ovf_full", overflow, 1'b0);
    for (int i = 4; i < 6; i++) begin
      res_nonce = 32'hC0DE0000 + 32'(i);
      tick;
    end
    man_busy = 1'b0;
    chk1("t5_outv", out_valid, 1'b1);
    chk("t5_head", 64'(out_nonce), 64'h00000000C0DE0000);
    chk1("t5_ovf", overflow, 1'b1);
    out_ready = 1'b1; man_busy = 1'b1; res_nonce = 32'hC0DE0006;
    tick;
    man_busy = 1'b0; res_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk1("t5_pop_v", out_valid, 1'b1);
      chk("t5_pop", 64'(out_nonce), 64'(t5n[i]));
      tick;
    end
    out_ready = 1'b0;
    chk1("t5_empty", out_valid, 1'b0);
    chk("t5_empty_nonce", 64'(out_nonce), 64'd0);
    chk("t5_found", 64'(stat_found), STATS ? 64'd7 : 64'd0);

    // 6: empty job, then abort in IDLE, then a one-word job
    job_valid = 1'b1; job_start = 32'h99; job_count = 32'd0;
    tick; job_valid = 1'b0;
    chk1("t6_done", done, 1'b1);
    chk1("t6_ovf_clr", overflow, 1'b0);
    chk1("t6_iv", issue_valid, 1'b0);
    tick;
    chk1("t6_done_clr", done, 1'b0);
    chk1("t6_iv2", issue_valid, 1'b0);
    chk1("t6_ready", job_ready, 1'b1);
    chk("t6_hashes", 64'(stat_hashes), STATS ? 64'd13 : 64'd0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk1("t6_abort_idle", sched_busy, 1'b0);
    job_valid = 1'b1; job_start = 32'h50; job_count = 32'd1; job_m04_hi = 32'h55550005;
    tick; job_valid = 1'b0;
    tick;
    chk("t6b_m04", issue_m04, {32'h55550005, bs(32'h50)});
    tick; tick; tick;
    chk1("t6b_done_early", done, 1'b0);
    tick;
    chk1("t6b_done", done, 1'b1);
    tick;

    // 7: reset mid-job clears everything at once
    man_busy = 1'b1; res_found = 1'b1; res_nonce = 32'h00000077;
    tick;
    man_busy = 1'b0; res_found = 1'b0;
    chk1("t7_fifo", out_valid, 1'b1);
    job_valid = 1'b1; job_start = 32'h60; job_count = 32'd100;
    tick; job_valid = 1'b0;
    tick; tick;
    #2 rst = 1'b1;
    #1;
    chk1("t7_ready", job_ready, 1'b1);
    chk1("t7_iv", issue_valid, 1'b0);
    chk1("t7_outv", out_valid, 1'b0);
    chk("t7_hashes", 64'(stat_hashes), 64'd0);
    chk("t7_found", 64'(stat_found), 64'd0);
    tick;
    rst = 1'b0;
    tick;
    chk1("t7_idle", sched_busy, 1'b0);
    chk1("t7_iv_post", issue_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
